// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C requester arbiter.
// FSM states, response codes and width helpers.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_RESPOND,
    ST_HOLDOFF
  } arb_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } rsp_err_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_REQ_NUM    = 4;
  localparam int ADDR_WIDTH     = DEF_DATA_WIDTH - 1;
  localparam int ID_WIDTH       = $clog2(DEF_REQ_NUM);

  function automatic int addr_w(input int dw);
    return dw - 1;
  endfunction

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin picker: first set request after `last`,
// scanning upward with wrap.
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter  int REQ_NUM = DEF_REQ_NUM,
  localparam int IW      = id_w(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               any,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] k;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    any = |req;
    idx = last;
    k   = last;
    for (int i = REQ_NUM; i >= 1; i--) begin
      k = IW'((int'(last) + i) % REQ_NUM);
      if (req[k]) idx = k;
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin share of one byte-level I2C master engine,
// with completion timeout and bus-free holdoff.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter  int REQ_NUM     = DEF_REQ_NUM,
  parameter  int PRESC_WIDTH = 16,
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int TMO_WIDTH   = 20,
  localparam int AW          = addr_w(DATA_WIDTH),
  localparam int IW          = id_w(REQ_NUM)
) (
  input  logic                    clk_i,
  input  logic                    s_rst_i,
  input  logic [PRESC_WIDTH-1:0]  prescale_i,
  input  logic [TMO_WIDTH-1:0]    timeout_i,
  input  logic [REQ_NUM-1:0]      req_valid_i,
  output logic [REQ_NUM-1:0]      req_ready_o,
  input  logic [REQ_NUM*AW-1:0]   req_addr_i,
  input  logic [REQ_NUM-1:0]      req_dir_i,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IW-1:0]           rsp_id_o,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic [1:0]              rsp_err_o,
  output logic                    m_en_o,
  output logic                    m_write_o,
  output logic                    m_stop_o,
  output logic                    m_dir_o,
  output logic [AW-1:0]           m_slave_addr_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic [PRESC_WIDTH-1:0]  m_prescale_o,
  input  logic                    m_done_i,
  input  logic                    m_nack_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i
);

  arb_state_t           state;
  logic [IW-1:0]        last;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic [PRESC_WIDTH-1:0] hold_cnt;
  logic                 tmo_hit;

  i2c_rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .req  (req_valid_i),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    req_ready_o = '0;
    if (state == ST_GRANT && pick_any)
      req_ready_o[pick_idx] = 1'b1;
  end

  assign tmo_hit = (timeout_i != '0) &&
    (tmo_cnt == timeout_i - TMO_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state          <= ST_IDLE;
      last           <= IW'(REQ_NUM - 1);
      tmo_cnt        <= '0;
      hold_cnt       <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_id_o       <= '0;
      rsp_data_o     <= '0;
      rsp_err_o      <= '0;
      m_en_o         <= 1'b0;
      m_write_o      <= 1'b0;
      m_stop_o       <= 1'b0;
      m_dir_o        <= 1'b0;
      m_slave_addr_o <= '0;
      m_data_o       <= '0;
      m_prescale_o   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req_valid_i) state <= ST_GRANT;
        end
        // Fields go straight onto the engine so m_en rises in LAUNCH.
        ST_GRANT: begin
          if (pick_any) begin
            last           <= pick_idx;
            m_slave_addr_o <= req_addr_i[int'(pick_idx)*AW +: AW];
            m_data_o       <= req_data_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            m_dir_o        <= req_dir_i[pick_idx];
            m_prescale_o   <= prescale_i;
            m_en_o         <= 1'b1;
            m_write_o      <= 1'b1;
            m_stop_o       <= 1'b1;
            state          <= ST_LAUNCH;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
          if (m_done_i || tmo_hit) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= last;
            m_en_o      <= 1'b0;
            m_write_o   <= 1'b0;
            m_stop_o    <= 1'b0;
            state       <= ST_RESPOND;
            if (m_done_i) begin
              rsp_data_o <= (m_dir_o && !m_nack_i) ? m_rdata_i : '0;
              rsp_err_o  <= m_nack_i ? ERR_NACK : ERR_OK;
            end else begin
              rsp_data_o <= '0;
              rsp_err_o  <= ERR_TIMEOUT;
            end
          end
        end
        ST_RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            hold_cnt    <= (m_prescale_o == '0) ?
              PRESC_WIDTH'(1) : m_prescale_o;
            state       <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt <= PRESC_WIDTH'(1)) state <= ST_IDLE;
          else hold_cnt <= hold_cnt - PRESC_WIDTH'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter; the bench plays
// the I2C engine and all requesters.
module tb_i2c_req_arbiter;

  logic        clk = 1'b0;
  logic        s_rst;
  logic [15:0] prescale;
  logic [19:0] timeout;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [27:0] req_addr;
  logic [3:0]  req_dir;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_err;
  logic        m_en, m_write, m_stop, m_dir;
  logic [6:0]  m_slave_addr;
  logic [7:0]  m_data;
  logic [15:0] m_prescale;
  logic        m_done, m_nack;
  logic [7:0]  m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter dut (
    .clk_i          (clk),
    .s_rst_i        (s_rst),
    .prescale_i     (prescale),
    .timeout_i      (timeout),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_dir_i      (req_dir),
    .req_data_i     (req_data),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_id_o       (rsp_id),
    .rsp_data_o     (rsp_data),
    .rsp_err_o      (rsp_err),
    .m_en_o         (m_en),
    .m_write_o      (m_write),
    .m_stop_o       (m_stop),
    .m_dir_o        (m_dir),
    .m_slave_addr_o (m_slave_addr),
    .m_data_o       (m_data),
    .m_prescale_o   (m_prescale),
    .m_done_i       (m_done),
    .m_nack_i       (m_nack),
    .m_rdata_i      (m_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the LAUNCH-cycle negedge; n = cycles waited past the first.
  task automatic grant(input logic [3:0] vld, output int g, output int n);
    n = 0;
    g = -1;
    req_valid = vld;
    @(negedge clk);
    while (req_ready == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++)
      if (req_ready[i]) g = i;
    @(negedge clk);
  endtask

  task automatic engine_done(input int dly, input logic nack,
                             input logic [7:0] rd);
    repeat (dly) @(negedge clk);
    m_done  = 1'b1;
    m_nack  = nack;
    m_rdata = rd;
    @(negedge clk);
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, n, bad;
    int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
    logic [1:0]  id0;
    logic [7:0]  d0;
    logic [1:0]  e0;

    s_rst     = 1'b1;
    prescale  = 16'd4;
    timeout   = 20'd0;
    req_valid = 4'b0;
    req_addr  = {7'h33, 7'h1A, 7'h22, 7'h50};
    req_dir   = 4'b0100;
    req_data  = {8'h44, 8'h00, 8'h11, 8'hA5};
    rsp_ready = 1'b0;
    m_done    = 1'b0;
    m_nack    = 1'b0;
    m_rdata   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {m_en, m_write, m_stop, m_dir, rsp_valid, req_ready}, 0);
    chk("rst_m_bus", {m_slave_addr, m_data, m_prescale}, 0);
    chk("rst_rsp", {rsp_id, rsp_data, rsp_err}, 0);
    s_rst = 1'b0;
    @(negedge clk);

    // single write from requester 0
    grant(4'b0001, g, n);
    req_valid = 4'b0;
    chk("wr_grant", g, 0);
    chk("wr_latency", n, 0);
    chk("wr_m_ctl", {m_en, m_write, m_stop, m_dir}, 4'b1110);
    chk("wr_m_addr", m_slave_addr, 7'h50);
    chk("wr_m_data", m_data, 8'hA5);
    chk("wr_m_presc", m_prescale, 16'd4);
    engine_done(200, 1'b0, 8'hFF);
    chk("wr_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 2'd0, 2'd0, 8'h00});
    chk("wr_m_en_low", {m_en, m_write, m_stop}, 0);
    consume();
    chk("wr_rsp_drop", rsp_valid, 0);

    // read from requester 2
    grant(4'b0100, g, n);
    req_valid = 4'b0;
    chk("rd_grant", g, 2);
    chk("rd_m", {m_dir, m_slave_addr}, {1'b1, 7'h1A});
    engine_done(10, 1'b0, 8'h3C);
    chk("rd_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 2'd2, 2'd0, 8'h3C});
    consume();

    // read NACK
    grant(4'b0100, g, n);
    req_valid = 4'b0;
    engine_done(10, 1'b1, 8'h77);
    chk("nack_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, 2'd2, 2'd1, 8'h00});
    consume();

    // reset during WAIT_DONE
    grant(4'b0010, g, n);
    req_valid = 4'b0;
    chk("mid_grant", g, 1);
    repeat (5) @(negedge clk);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    chk("mid_rst_ctl", {m_en, m_write, m_stop, rsp_valid}, 0);
    chk("mid_rst_bus", {m_slave_addr, m_data}, 0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("mid_no_rsp", bad, 0);

    // round robin with 0,1,3 held high
    for (int i = 0; i < 6; i++) begin
      grant(4'b1011, g, n);
      chk($sformatf("rr_grant%0d", i), g, rr_exp[i]);
      engine_done(5, 1'b0, 8'h00);
      chk($sformatf("rr_id%0d", i), rsp_id, rr_exp[i]);
      consume();
    end
    req_valid = 4'b0;
    repeat (8) @(negedge clk);

    // timeout with no done pulse
    timeout = 20'd100;
    grant(4'b0001, g, n);
    req_valid = 4'b0;
    chk("tmo_grant", g, 0);
    n = 0;
    while (m_en === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_len", n, 101);
    chk("tmo_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 2'd2, 8'h00});
    consume();

    // done coincides with the timeout cycle
    req_dir[0] = 1'b1;
    grant(4'b0001, g, n);
    req_valid = 4'b0;
    engine_done(100, 1'b0, 8'h11);
    chk("tmo_tie", {rsp_valid, rsp_err, rsp_data}, {1'b1, 2'd0, 8'h11});
    consume();
    timeout = 20'd0;
    req_dir[0] = 1'b0;

    // backpressure then holdoff with prescale 10
    prescale = 16'd10;
    grant(4'b0010, g, n);
    req_valid = 4'b0;
    engine_done(3, 1'b0, 8'h00);
    id0 = rsp_id;
    d0  = rsp_data;
    e0  = rsp_err;
    chk("bp_id", id0, 1);
    req_valid = 4'b1001;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_data !== d0 ||
          rsp_err !== e0 || req_ready !== 4'b0) bad++;
    end
    chk("bp_stable", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n = 1;
    while (req_ready == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_gap", n, 12);
    chk("hold_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0;
    engine_done(3, 1'b0, 8'h00);
    chk("hold_rsp_id", rsp_id, 3);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
